// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder with a req/Ready handshake, wait states and address checking.
// Optional DMEM_STATS_EN adds saturating ReadCount/WriteCount outputs for completed loads/stores.
module data_mem_responder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [31:0]           Addr,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Ready,
  output logic                  Busy,
  output logic                  AddrError
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]           ReadCount,
  output logic [15:0]           WriteCount
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  is_load_q, is_load_d;
  logic                  err_q, err_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  aerr_q, aerr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  mem_we;
`ifdef DMEM_STATS_EN
  logic [15:0]           rd_cnt_q, rd_cnt_d;
  logic [15:0]           wr_cnt_q, wr_cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    is_load_d = is_load_q;
    err_d     = err_q;
    ready_d   = 1'b0;
    busy_d    = busy_q;
    aerr_d    = 1'b0;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
`ifdef DMEM_STATS_EN
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (MemRead || MemWrite) begin
          idx_d     = Addr[IDX_W+1:2];
          wdata_d   = WriteData;
          is_load_d = MemRead;
          err_d     = (Addr[1:0] != 2'b00) || (|Addr[31:IDX_W+2]) || (MemRead && MemWrite);
          cnt_d     = 4'(WAIT_CYCLES);
          state_d   = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
          busy_d    = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_DONE;
      end
      S_DONE: begin
        // Outputs are registered: Ready, ReadData and the store land on the edge leaving this state.
        state_d = S_IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        aerr_d  = err_q;
        if (!err_q) begin
          if (is_load_q) rdata_d = mem[idx_q];
          else           mem_we  = 1'b1;
`ifdef DMEM_STATS_EN
          if (is_load_q && rd_cnt_q != 16'hFFFF)  rd_cnt_d = rd_cnt_q + 16'd1;
          if (!is_load_q && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      is_load_q <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      aerr_q    <= 1'b0;
      rdata_q   <= '0;
`ifdef DMEM_STATS_EN
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      is_load_q <= is_load_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      aerr_q    <= aerr_d;
      rdata_q   <= rdata_d;
`ifdef DMEM_STATS_EN
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
`endif
    end
  end

  // Storage is deliberately left out of reset; a reset edge only suppresses the pending write.
  always_ff @(posedge Clk) begin
    if (mem_we && !Rst) mem[idx_q] <= wdata_q;
  end

  assign ReadData  = rdata_q;
  assign Ready     = ready_q;
  assign Busy      = busy_q;
  assign AddrError = aerr_q;
`ifdef DMEM_STATS_EN
  assign ReadCount  = rd_cnt_q;
  assign WriteCount = wr_cnt_q;
`endif

endmodule
